// File: rtl/lc3b_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for lc3b_mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface lc3b_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
);
    logic              if_read;
    logic [ADDR_W-1:0] if_address;
    logic              if_resp;
    logic [DATA_W-1:0] if_rdata;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_byte_enable;
    logic              d_resp;
    logic [DATA_W-1:0] d_rdata;

    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [MASK_W-1:0] pmem_byte_enable;
    logic              pmem_resp;
    logic [DATA_W-1:0] pmem_rdata;

    logic              busy;

    modport slave (
        input  if_read, if_address,
        output if_resp, if_rdata,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        output d_resp, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  pmem_resp, pmem_rdata,
        output busy
    );

    modport master (
        output if_read, if_address,
        input  if_resp, if_rdata,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  d_resp, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output pmem_resp, pmem_rdata,
        input  busy
    );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Shares one memory port between LC-3b instruction fetch and data access.
// Define LC3B_MEM_ARB_RR_EN for round-robin arbitration; default is data priority.
module lc3b_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = 2
) (
    input logic                clk,
    input logic                rst_n,
    lc3b_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D} state_e;

    state_e            state_q;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] be_q;

    logic pend_if;
    logic pend_d;
    logic grant_d;

    assign pend_if = bus.if_read;
    assign pend_d  = bus.d_read | bus.d_write;

`ifdef LC3B_MEM_ARB_RR_EN
    logic last_d_q;
    // On a tie the requester that was not served last wins.
    assign grant_d = pend_d & (~pend_if | ~last_d_q);
`else
    assign grant_d = pend_d;
`endif

    // NOTE: all state lives in this one clocked block and uses <= so every
    // register samples the same pre-edge values; blocking = here would race.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '1;
`ifdef LC3B_MEM_ARB_RR_EN
            last_d_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q <= SERVE_D;
                        rd_q    <= bus.d_read & ~bus.d_write;
                        wr_q    <= bus.d_write;
                        addr_q  <= bus.d_address;
                        wdata_q <= bus.d_wdata;
                        be_q    <= bus.d_byte_enable;
`ifdef LC3B_MEM_ARB_RR_EN
                        last_d_q <= 1'b1;
`endif
                    end else if (pend_if) begin
                        state_q <= SERVE_IF;
                        rd_q    <= 1'b1;
                        wr_q    <= 1'b0;
                        addr_q  <= bus.if_address;
                        wdata_q <= '0;
                        be_q    <= '1;
`ifdef LC3B_MEM_ARB_RR_EN
                        last_d_q <= 1'b0;
`endif
                    end
                end
                SERVE_IF, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pmem_read        = rd_q;
    assign bus.pmem_write       = wr_q;
    assign bus.pmem_address     = addr_q;
    assign bus.pmem_wdata       = wdata_q;
    assign bus.pmem_byte_enable = be_q;

    // Completion is routed only to the owner; a stray pmem_resp in IDLE is dropped.
    assign bus.if_resp  = (state_q == SERVE_IF) & bus.pmem_resp;
    assign bus.d_resp   = (state_q == SERVE_D)  & bus.pmem_resp;
    assign bus.if_rdata = bus.pmem_rdata;
    assign bus.d_rdata  = bus.pmem_rdata;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: doc/lc3b_mem_arbiter.md
# lc3b_mem_arbiter

Two-port to one-port memory arbiter for the LC-3b multicycle core. It shares the single physical memory port between the instruction-fetch requester (fetch states) and the data requester (LDR/STR/LDB/STB/LDI/STI states). It latches each granted request and holds it on the memory port until `pmem_resp`. It routes the response back to the owning requester only, so the control FSMs keep their existing `mem_read`/`mem_write`/`mem_resp` handshake unchanged.

## Interface
Parameters:
- `ADDR_W`, 16, address width (lc3b_word).
- `DATA_W`, 16, data width.
- `MASK_W`, 2, byte-enable width (lc3b_mem_wmask).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `if_read`  in  1  instruction-fetch read request.
- `if_address`  in  ADDR_W  fetch address.
- `if_resp`  out  1  fetch completion pulse.
- `if_rdata`  out  DATA_W  fetch read data.
- `d_read`  in  1  data read request.
- `d_write`  in  1  data write request.
- `d_address`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  data write data.
- `d_byte_enable`  in  MASK_W  data write byte mask.
- `d_resp`  out  1  data completion pulse.
- `d_rdata`  out  DATA_W  data read data.
- `pmem_read`  out  1  physical memory read.
- `pmem_write`  out  1  physical memory write.
- `pmem_address`  out  ADDR_W  physical address.
- `pmem_wdata`  out  DATA_W  physical write data.
- `pmem_byte_enable`  out  MASK_W  physical byte mask.
- `pmem_resp`  in  1  physical completion, one-cycle pulse.
- `pmem_rdata`  in  DATA_W  physical read data, valid with `pmem_resp`.
- `busy`  out  1  high while a transaction is outstanding (state != IDLE).

## Operation
- FSM states: IDLE, SERVE_IF, SERVE_D.
- IDLE: a requester is pending if `if_read`, or if `d_read|d_write`.
  - If any requester is pending, select a winner by the arbitration rule.
  - Register `{read, write, address, wdata, byte_enable}` from the winner. Fetch latches write=0, wdata=0, byte_enable=2'b11.
  - Go to SERVE_IF or SERVE_D.
- SERVE_x:
  - `pmem_*` are driven from the latched registers only. Requester inputs are ignored.
  - On `pmem_resp`, pulse `x_resp` in the same cycle (combinational from `pmem_resp` gated by state), then go to IDLE.
  - Without `pmem_resp`, stay in SERVE_x.
- The non-owner `_resp` is never asserted.
- `if_rdata` and `d_rdata` both equal `pmem_rdata` at all times. They are meaningful only with their own `_resp`.
- `d_read` and `d_write` both high: treated as a write; read is ignored.
- Arbitration (fixed priority, default): data beats fetch on a simultaneous request.
- The requester keeps its request asserted until its `_resp`. A request dropped before its grant is simply not served. A request dropped after its grant still completes on memory; its `_resp` still pulses.

## Timing
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `pmem_byte_enable`=2'b11, `if_resp`=0, `d_resp`=0, `busy`=0, state=IDLE.
- Latency:
  - Request visible at edge N (in IDLE).
  - `pmem_read`/`pmem_write` asserted from cycle N+1.
  - `x_resp` pulses in the cycle `pmem_resp` arrives, at cycle N+1 or later.
- After a `_resp`, the next cycle is IDLE with `pmem_read`=`pmem_write`=0. Back-to-back transactions are therefore at least 2 cycles apart on the memory port.
- `pmem_*` are stable for the entire SERVE state.
- `rst_n` low mid-transaction: immediately go to IDLE and force all outputs to reset values. The in-flight transaction is abandoned. A late `pmem_resp` arriving in IDLE is ignored and produces no `_resp`.

## Configuration
- `LC3B_MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit `last_d` register is set when SERVE_D is entered and cleared when SERVE_IF is entered.
  - On a simultaneous request, the requester not served last wins.
  - Reset value of `last_d` is 1, so fetch wins the first tie.
- Macro undefined: fixed data priority; no `last_d` register.

## Test plan
- Single fetch: `if_read`=1, `if_address`=0x0040. Memory responds 3 cycles after the command with 0x1234. Required: `pmem_read`=1 and `pmem_address`=0x0040 from N+1; `if_resp` pulses once with `if_rdata`=0x1234; `d_resp` stays 0.
- Data write: `d_write`=1, `d_address`=0x0100, `d_wdata`=0xBEEF, `d_byte_enable`=2'b01. Change `d_address` to 0x0200 mid-transaction. Required: `pmem_address` stays 0x0100 and `pmem_byte_enable`=2'b01 until `pmem_resp`, then `d_resp` pulses.
- Simultaneous `if_read` and `d_read` held continuously.
  - Fixed priority: data served first, then fetch.
  - RR: fetch first (reset tie), then data, then alternation.
- Reset mid-transaction: assert `rst_n`=0 during SERVE_D. Required: `pmem_read`/`pmem_write`=0 and `busy`=0 asynchronously. A `pmem_resp` pulse 1 cycle after release yields no `_resp`.
- `d_read`=`d_write`=1 with `d_wdata`=0x00FF. Required: `pmem_write`=1, `pmem_read`=0.
- Zero-wait memory (`pmem_resp` in the first command cycle): requests alternate every 2 cycles. No `_resp` is double-pulsed.
